// File: rtl/instr_ctrl_if.sv
// Handshake and datapath-control bundle between the Simple RISC Machine
// instruction controller (slave side) and whatever loads and starts instructions.
interface instr_ctrl_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic        err;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        asel;
  logic        bsel;
  logic        loadc;
  logic        loads;
  logic        write;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm5;
  logic [15:0] sximm8;

  modport master (
    output s, load, in,
    input  w, err, readnum, writenum, vsel, loada, loadb, asel, bsel,
           loadc, loads, write, shift, ALUop, sximm5, sximm8
  );

  modport slave (
    input  s, load, in,
    output w, err, readnum, writenum, vsel, loada, loadb, asel, bsel,
           loadc, loads, write, shift, ALUop, sximm5, sximm8
  );
endinterface

// File: rtl/instr_ctrl.sv
// Instruction register, decoder and multi-cycle control FSM for the Simple RISC Machine.
// Optional feature macro: INSTR_CTRL_ILLEGAL_TRAP_EN (illegal opcodes trap into HALT).
module instr_ctrl (
  input logic        clk,
  input logic        reset,
  instr_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE_IMM = 3'd2,
    ST_GET_A     = 3'd3,
    ST_GET_B     = 3'd4,
    ST_ALU       = 3'd5,
    ST_WRITE_REG = 3'd6,
    ST_HALT      = 3'd7
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] ir_r;

  logic [2:0] opcode_s;
  logic [1:0] op_s;
  logic [2:0] rn_s;
  logic [2:0] rd_s;
  logic [1:0] sh_s;
  logic [2:0] rm_s;

  logic is_mov_imm_s;
  logic is_mov_reg_s;
  logic is_add_s;
  logic is_cmp_s;
  logic is_and_s;
  logic is_mvn_s;
  logic is_alu3_s;

  logic       w_r, w_nxt_s;
  logic [2:0] readnum_r, readnum_nxt_s;
  logic [2:0] writenum_r, writenum_nxt_s;
  logic [1:0] vsel_r, vsel_nxt_s;
  logic       loada_r, loada_nxt_s;
  logic       loadb_r, loadb_nxt_s;
  logic       asel_r, asel_nxt_s;
  logic       bsel_r, bsel_nxt_s;
  logic       loadc_r, loadc_nxt_s;
  logic       loads_r, loads_nxt_s;
  logic       write_r, write_nxt_s;
  logic [1:0] shift_r, shift_nxt_s;
  logic [1:0] aluop_r, aluop_nxt_s;
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
  logic       err_r, err_nxt_s;
`endif

  assign opcode_s = ir_r[15:13];
  assign op_s     = ir_r[12:11];
  assign rn_s     = ir_r[10:8];
  assign rd_s     = ir_r[7:5];
  assign sh_s     = ir_r[4:3];
  assign rm_s     = ir_r[2:0];

  assign bus.sximm8 = {{8{ir_r[7]}}, ir_r[7:0]};
  assign bus.sximm5 = {{11{ir_r[4]}}, ir_r[4:0]};

  assign is_mov_imm_s = (opcode_s == 3'b110) && (op_s == 2'b10);
  assign is_mov_reg_s = (opcode_s == 3'b110) && (op_s == 2'b00);
  assign is_add_s     = (opcode_s == 3'b101) && (op_s == 2'b00);
  assign is_cmp_s     = (opcode_s == 3'b101) && (op_s == 2'b01);
  assign is_and_s     = (opcode_s == 3'b101) && (op_s == 2'b10);
  assign is_mvn_s     = (opcode_s == 3'b101) && (op_s == 2'b11);
  assign is_alu3_s    = is_add_s || is_cmp_s || is_and_s;

  // Next-state selection; DECODE always sees the word latched on the WAIT exit edge.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_WAIT: begin
        if (bus.s) state_nxt_s = ST_DECODE;
        else       state_nxt_s = ST_WAIT;
      end
      ST_DECODE: begin
        if (is_mov_imm_s)                    state_nxt_s = ST_WRITE_IMM;
        else if (is_alu3_s)                  state_nxt_s = ST_GET_A;
        else if (is_mov_reg_s || is_mvn_s)   state_nxt_s = ST_GET_B;
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
        else                                 state_nxt_s = ST_HALT;
`else
        else                                 state_nxt_s = ST_WAIT;
`endif
      end
      ST_WRITE_IMM: state_nxt_s = ST_WAIT;
      ST_GET_A:     state_nxt_s = ST_GET_B;
      ST_GET_B:     state_nxt_s = ST_ALU;
      ST_ALU: begin
        if (is_cmp_s) state_nxt_s = ST_WAIT;
        else          state_nxt_s = ST_WRITE_REG;
      end
      ST_WRITE_REG: state_nxt_s = ST_WAIT;
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
      ST_HALT:      state_nxt_s = ST_HALT;
`else
      ST_HALT:      state_nxt_s = ST_WAIT;
`endif
      default:      state_nxt_s = ST_WAIT;
    endcase
  end

  // Moore outputs for the state being entered, so they can be registered alongside it.
  always_comb begin
    w_nxt_s        = 1'b0;
    readnum_nxt_s  = 3'd0;
    writenum_nxt_s = 3'd0;
    vsel_nxt_s     = 2'b00;
    loada_nxt_s    = 1'b0;
    loadb_nxt_s    = 1'b0;
    asel_nxt_s     = 1'b0;
    bsel_nxt_s     = 1'b0;
    loadc_nxt_s    = 1'b0;
    loads_nxt_s    = 1'b0;
    write_nxt_s    = 1'b0;
    shift_nxt_s    = 2'b00;
    aluop_nxt_s    = 2'b00;
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
    err_nxt_s      = 1'b0;
`endif
    case (state_nxt_s)
      ST_WAIT: w_nxt_s = 1'b1;
      ST_WRITE_IMM: begin
        write_nxt_s    = 1'b1;
        writenum_nxt_s = rn_s;
        vsel_nxt_s     = 2'b10;
      end
      ST_GET_A: begin
        loada_nxt_s   = 1'b1;
        readnum_nxt_s = rn_s;
      end
      ST_GET_B: begin
        loadb_nxt_s   = 1'b1;
        readnum_nxt_s = rm_s;
      end
      ST_ALU: begin
        loadc_nxt_s = 1'b1;
        shift_nxt_s = sh_s;
        bsel_nxt_s  = 1'b0;
        // MOV reg reuses ADD with A forced to zero; MVN also ignores A.
        if (opcode_s == 3'b101) aluop_nxt_s = op_s;
        else                    aluop_nxt_s = 2'b00;
        asel_nxt_s  = is_mov_reg_s || is_mvn_s;
        loads_nxt_s = is_cmp_s;
      end
      ST_WRITE_REG: begin
        write_nxt_s    = 1'b1;
        writenum_nxt_s = rd_s;
        vsel_nxt_s     = 2'b00;
      end
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
      ST_HALT: err_nxt_s = 1'b1;
`endif
      default: w_nxt_s = 1'b0;
    endcase
  end

  // State, instruction register and registered control outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_WAIT;
      ir_r       <= 16'h0000;
      w_r        <= 1'b1;
      readnum_r  <= 3'd0;
      writenum_r <= 3'd0;
      vsel_r     <= 2'b00;
      loada_r    <= 1'b0;
      loadb_r    <= 1'b0;
      asel_r     <= 1'b0;
      bsel_r     <= 1'b0;
      loadc_r    <= 1'b0;
      loads_r    <= 1'b0;
      write_r    <= 1'b0;
      shift_r    <= 2'b00;
      aluop_r    <= 2'b00;
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
      err_r      <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == ST_WAIT) && bus.load) ir_r <= bus.in;
      else                                  ir_r <= ir_r;
      w_r        <= w_nxt_s;
      readnum_r  <= readnum_nxt_s;
      writenum_r <= writenum_nxt_s;
      vsel_r     <= vsel_nxt_s;
      loada_r    <= loada_nxt_s;
      loadb_r    <= loadb_nxt_s;
      asel_r     <= asel_nxt_s;
      bsel_r     <= bsel_nxt_s;
      loadc_r    <= loadc_nxt_s;
      loads_r    <= loads_nxt_s;
      write_r    <= write_nxt_s;
      shift_r    <= shift_nxt_s;
      aluop_r    <= aluop_nxt_s;
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
      err_r      <= err_nxt_s;
`endif
    end
  end

  assign bus.w        = w_r;
  assign bus.readnum  = readnum_r;
  assign bus.writenum = writenum_r;
  assign bus.vsel     = vsel_r;
  assign bus.loada    = loada_r;
  assign bus.loadb    = loadb_r;
  assign bus.asel     = asel_r;
  assign bus.bsel     = bsel_r;
  assign bus.loadc    = loadc_r;
  assign bus.loads    = loads_r;
  assign bus.write    = write_r;
  assign bus.shift    = shift_r;
  assign bus.ALUop    = aluop_r;
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
  assign bus.err      = err_r;
`else
  assign bus.err      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_ctrl.sv
// Directed cycle-by-cycle bench for instr_ctrl; expected traces are hand-derived
// from the instruction encodings.
module tb_instr_ctrl;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  instr_ctrl_if bus();

  instr_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {w, err, loada, loadb, asel, bsel, loadc, loads, write, readnum, writenum, vsel, shift, ALUop}
  function automatic logic [20:0] pk(input logic w, input logic e, input logic [6:0] strb,
                                     input logic [2:0] rn, input logic [2:0] wn,
                                     input logic [1:0] vs, input logic [1:0] sh,
                                     input logic [1:0] alu);
    return {w, e, strb, rn, wn, vs, sh, alu};
  endfunction

  function automatic logic [20:0] snap();
    return {bus.w, bus.err, bus.loada, bus.loadb, bus.asel, bus.bsel, bus.loadc,
            bus.loads, bus.write, bus.readnum, bus.writenum, bus.vsel, bus.shift, bus.ALUop};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_instr(input logic [15:0] word);
    bus.in   = word;
    bus.load = 1'b1;
    bus.s    = 1'b1;
    step();
    bus.load = 1'b0;
    bus.s    = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    got = snap();
    checks++;
    if (got !== pk(1'b1, 1'b0, 7'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", got,
               pk(1'b1, 1'b0, 7'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0));
    end
    checks++;
    if (bus.sximm8 !== 16'h0000 || bus.sximm5 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_ir: got sximm8=%h sximm5=%h expected 0000 0000", bus.sximm8, bus.sximm5);
    end
  endtask

  task automatic test_mov_imm();
    logic [20:0] exp_q [3];
    logic [20:0] got;
    exp_q[0] = pk(1'b0, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'd0, 2'd0);
    exp_q[1] = pk(1'b0, 1'b0, 7'b0000001, 3'd0, 3'd0, 2'b10, 2'd0, 2'd0);
    exp_q[2] = pk(1'b1, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'd0, 2'd0);
    start_instr(16'hD012);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      got = snap();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL mov_imm_cycle%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (bus.sximm8 !== 16'd18 || bus.sximm5 !== 16'hFFF2) begin
      errors++;
      $display("FAIL mov_imm_sximm: got %h %h expected 0012 fff2", bus.sximm8, bus.sximm5);
    end
  endtask

  task automatic test_add();
    logic [20:0] exp_q [6];
    logic [20:0] got;
    exp_q[0] = pk(1'b0, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[1] = pk(1'b0, 1'b0, 7'b1000000, 3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[2] = pk(1'b0, 1'b0, 7'b0100000, 3'd1, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[3] = pk(1'b0, 1'b0, 7'b0000100, 3'd0, 3'd0, 2'b00, 2'b01, 2'b00);
    exp_q[4] = pk(1'b0, 1'b0, 7'b0000001, 3'd0, 3'd2, 2'b00, 2'b00, 2'b00);
    exp_q[5] = pk(1'b1, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    start_instr(16'hA049);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      // a load pulse mid-instruction must not disturb the IR
      if (i == 1) begin
        bus.in   = 16'hFFFF;
        bus.load = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      got = snap();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL add_cycle%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
    checks++;
    if (bus.sximm8 !== 16'h0049) begin
      errors++;
      $display("FAIL add_ir_hold: got sximm8=%h expected 0049", bus.sximm8);
    end
  endtask

  task automatic test_cmp();
    logic [20:0] exp_q [5];
    logic [20:0] got;
    exp_q[0] = pk(1'b0, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[1] = pk(1'b0, 1'b0, 7'b1000000, 3'd2, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[2] = pk(1'b0, 1'b0, 7'b0100000, 3'd3, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[3] = pk(1'b0, 1'b0, 7'b0000110, 3'd0, 3'd0, 2'b00, 2'b00, 2'b01);
    exp_q[4] = pk(1'b1, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    start_instr(16'hAA03);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      got = snap();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL cmp_cycle%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  task automatic test_mvn();
    logic [20:0] exp_q [5];
    logic [20:0] got;
    exp_q[0] = pk(1'b0, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[1] = pk(1'b0, 1'b0, 7'b0100000, 3'd5, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[2] = pk(1'b0, 1'b0, 7'b0010100, 3'd0, 3'd0, 2'b00, 2'b00, 2'b11);
    exp_q[3] = pk(1'b0, 1'b0, 7'b0000001, 3'd0, 3'd6, 2'b00, 2'b00, 2'b00);
    exp_q[4] = pk(1'b1, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    start_instr(16'hB8C5);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      got = snap();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL mvn_cycle%0d: got %h expected %h", i, got, exp_q[i]);
      end
    end
  endtask

  // MOV R5,#-1 then MOV R5,R3 with s held high: only the single WAIT cycle separates them.
  task automatic test_back_to_back();
    logic [20:0] exp_q [8];
    logic [20:0] got;
    exp_q[0] = pk(1'b0, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[1] = pk(1'b0, 1'b0, 7'b0000001, 3'd0, 3'd5, 2'b10, 2'b00, 2'b00);
    exp_q[2] = pk(1'b1, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[3] = pk(1'b0, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[4] = pk(1'b0, 1'b0, 7'b0100000, 3'd3, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[5] = pk(1'b0, 1'b0, 7'b0010100, 3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    exp_q[6] = pk(1'b0, 1'b0, 7'b0000001, 3'd0, 3'd5, 2'b00, 2'b00, 2'b00);
    exp_q[7] = pk(1'b1, 1'b0, 7'd0,        3'd0, 3'd0, 2'b00, 2'b00, 2'b00);
    bus.in   = 16'hD5FF;
    bus.load = 1'b1;
    bus.s    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      case (i)
        0:       bus.load = 1'b0;
        1: begin bus.in = 16'hC0A3; bus.load = 1'b1; end
        3: begin bus.load = 1'b0; bus.s = 1'b0; end
        default: bus.load = bus.load;
      endcase
      got = snap();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got %h expected %h", i, got, exp_q[i]);
      end
      if (i == 1) begin
        checks++;
        if (bus.sximm8 !== 16'hFFFF) begin
          errors++;
          $display("FAIL b2b_sximm8_neg: got %h expected ffff", bus.sximm8);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [20:0] got;
    start_instr(16'h0000);
    got = snap();
    checks++;
    if (got !== pk(1'b0, 1'b0, 7'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0)) begin
      errors++;
      $display("FAIL illegal_decode: got %h", got);
    end
`ifdef INSTR_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 12; i++) begin
      step();
      got = snap();
      checks++;
      if (got !== pk(1'b0, 1'b1, 7'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0)) begin
        errors++;
        $display("FAIL illegal_halt_cycle%0d: got %h expected %h", i, got,
                 pk(1'b0, 1'b1, 7'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0));
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    got = snap();
    checks++;
    if (got !== pk(1'b1, 1'b0, 7'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0)) begin
      errors++;
      $display("FAIL illegal_reset_exit: got %h", got);
    end
`else
    for (int i = 0; i < 3; i++) begin
      step();
      got = snap();
      checks++;
      if (got !== pk(1'b1, 1'b0, 7'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0)) begin
        errors++;
        $display("FAIL illegal_nop_cycle%0d: got %h expected %h", i, got,
                 pk(1'b1, 1'b0, 7'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0));
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [20:0] got;
    start_instr(16'hA049);
    step();
    step();
    got = snap();
    checks++;
    if (got !== pk(1'b0, 1'b0, 7'b0100000, 3'd1, 3'd0, 2'd0, 2'd0, 2'd0)) begin
      errors++;
      $display("FAIL rstmid_get_b: got %h", got);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    got = snap();
    checks++;
    if (got !== pk(1'b1, 1'b0, 7'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0) || bus.sximm8 !== 16'h0000) begin
      errors++;
      $display("FAIL rstmid_wait: got %h sximm8=%h expected %h 0000", got, bus.sximm8,
               pk(1'b1, 1'b0, 7'd0, 3'd0, 3'd0, 2'd0, 2'd0, 2'd0));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.write !== 1'b0 || bus.w !== 1'b1) begin
        errors++;
        $display("FAIL rstmid_no_write%0d: got write=%b w=%b expected 0 1", i, bus.write, bus.w);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors   = 0;
    checks   = 0;
    reset    = 1'b1;
    bus.s    = 1'b0;
    bus.load = 1'b0;
    bus.in   = 16'h0000;
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_mvn();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
